i2c_slave_reg: RTL

- Single-register I2C responder; the target end of the bus driven by the multi-rate I2C master (i2c_top_multi).
- Oversamples SCL/SDA on the system clock, so it works at any master baud setting with SCL period >= 16 clk cycles.
- Responds to one 7-bit address.
- Holds one 8-bit data register: a master write overwrites it; a master read returns it.
- Several instances with distinct addresses share one bus in the system testbench.

---
 rtl/i2c_slave_reg.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_reg.sv
// Single-register I2C target: oversamples SCL/SDA on clk, ACKs one 7-bit address and
// exposes one 8-bit register that master writes overwrite and master reads return.
module i2c_slave_reg #(
    parameter logic [6:0]  SLV_ADDR    = 7'b1011000,
    parameter logic [7:0]  INIT_DATA   = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_data,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       busy
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SHF_W = 7;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP, IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_dly_q, scl_dly_d;
    logic                   sda_dly_q, sda_dly_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SHF_W-1:0]       shift_q, shift_d;
    logic                   rw_q, rw_d;
    logic                   phase_q, phase_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             reg_data_q, reg_data_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   rd_strobe_q, rd_strobe_d;
    logic                   busy_q, busy_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    // Synchronizer chains plus one delayed copy for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_dly_d  = scl_sync_q[SYNC_STAGES-1];
        sda_dly_d  = sda_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_data_q  <= INIT_DATA;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            sda_oe_q    <= sda_oe_d;
            reg_data_q  <= reg_data_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            busy_q      <= busy_d;
        end
    end

    // phase_q: in the ACK states it marks "ACK being driven"; in READ_ACK it marks "master ACKed".
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        sda_oe_d    = sda_oe_q;
        reg_data_d  = reg_data_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        busy_d      = busy_q;

        if (stop_det || start_det) begin
            state_d   = stop_det ? IDLE : ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[SHF_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rw_d = sda_s;
                            if (shift_q == SLV_ADDR) begin
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == WRITE_ACK || !rw_q) begin
                                state_d = WRITE;
                            end else begin
                                state_d  = READ;
                                shift_d  = reg_data_q[SHF_W-1:0];
                                sda_oe_d = ~reg_data_q[7];
                            end
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[SHF_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            reg_data_d  = {shift_q, sda_s};
                            wr_strobe_d = 1'b1;
                            state_d     = WRITE_ACK;
                        end
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(7)) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = READ_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[SHF_W-1];
                            shift_d   = {shift_q[SHF_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !phase_q) begin
                        rd_strobe_d = 1'b1;
                        if (sda_s) state_d = WAIT_STOP;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        shift_d   = reg_data_q[SHF_W-1:0];
                        sda_oe_d  = ~reg_data_q[7];
                        state_d   = READ;
                    end
                end
                WAIT_STOP, IGNORE: sda_oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_data  = reg_data_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;

endmodule
